// File: rtl/gd_iter_ctrl_if.sv
// Responder handshake between gd_iter_ctrl (master) and the finite-difference
// gradient/value block (slave): launch pulse plus point out, step/value/overflow back.
interface gd_iter_ctrl_if;
    logic        start_func;
    logic [31:0] x_in;
    logic        func_done;
    logic [31:0] x_diff_out;
    logic [63:0] value;
    logic        overflow;

    modport master (
        output start_func, x_in,
        input  func_done, x_diff_out, value, overflow
    );

    modport slave (
        input  start_func, x_in,
        output func_done, x_diff_out, value, overflow
    );
endinterface

// File: rtl/gd_iter_ctrl.sv
// Gradient-descent iteration controller.
// Launches the gradient/value responder at the current point, takes its scaled
// step, and iterates x <- x - step until |step| <= TOL, MAX_ITER evaluations,
// or a responder overflow; then reports the final point and value.
// Optional per-evaluation watchdog: define GD_TIMEOUT_EN.
module gd_iter_ctrl #(
    parameter int unsigned MAX_ITER    = 64,
    parameter logic [31:0] TOL         = 32'h0000_0001,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           x_init,
    gd_iter_ctrl_if.master        rsp,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic                  err_ovf,
    output logic                  err_timeout,
    output logic [31:0]           x_opt,
    output logic [63:0]           value_opt,
    output logic [15:0]           iter_count
);

    if (MAX_ITER == 0 || MAX_ITER > 65535) begin : g_bad_max_iter
        $error("gd_iter_ctrl: MAX_ITER must be 1..65535");
    end
    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("gd_iter_ctrl: TIMEOUT_CYC must be 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;

    logic [31:0] x_cur;
    logic [31:0] cap_diff;
    logic [63:0] cap_value;
    logic        cap_ovf;

    logic [32:0] sub_wide;
    logic [31:0] x_next;
    logic [31:0] diff_abs;
    logic [15:0] iter_inc;
    logic        hit_tol;
    logic        hit_limit;
    logic        timeout_hit;
    logic        start_func_c;

    // Step arithmetic for UPDATE: saturating subtract, step magnitude, stop tests
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path,
        // otherwise synthesis infers a latch to hold the old one.
        sub_wide = {x_cur[31], x_cur} - {cap_diff[31], cap_diff};
        if (sub_wide[32] != sub_wide[31])
            x_next = sub_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            x_next = sub_wide[31:0];

        // The most negative step has no positive twin; clamp its magnitude.
        if (cap_diff == 32'h8000_0000)
            diff_abs = 32'h7FFF_FFFF;
        else if (cap_diff[31])
            diff_abs = -cap_diff;
        else
            diff_abs = cap_diff;

        iter_inc  = iter_count + 16'd1;
        hit_tol   = (diff_abs <= TOL);
        hit_limit = (iter_inc == 16'(MAX_ITER));
    end

`ifdef GD_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        waiting;

    assign waiting     = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
    assign timeout_hit = waiting && (wd_cnt == 16'(TIMEOUT_CYC - 1));

    // Watchdog: restarts at each launch, counts while waiting on the responder
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == S_LAUNCH)
                wd_cnt <= '0;
            else if (waiting)
                wd_cnt <= wd_cnt + 16'd1;

            if (state == S_IDLE && start)
                err_timeout <= 1'b0;
            else if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; rst_n low between edges
        // has no effect until the next rising edge.
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_LAUNCH;
            S_LAUNCH:    state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (timeout_hit)        state_nxt = S_DONE;
                else if (!rsp.func_done) state_nxt = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (timeout_hit)        state_nxt = S_DONE;
                else if (rsp.func_done) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                if (cap_ovf || hit_tol || hit_limit) state_nxt = S_DONE;
                else                                 state_nxt = S_LAUNCH;
            end
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        start_func_c = (state == S_LAUNCH);
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
    end

    assign rsp.start_func = start_func_c;
    assign rsp.x_in       = x_cur;

    // Datapath: point, captured response, result registers and flags
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            x_cur      <= '0;
            cap_diff   <= '0;
            cap_value  <= '0;
            cap_ovf    <= 1'b0;
            iter_count <= '0;
            converged  <= 1'b0;
            err_ovf    <= 1'b0;
            x_opt      <= '0;
            value_opt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_cur      <= x_init;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        err_ovf    <= 1'b0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rsp.func_done) begin
                        cap_diff  <= rsp.x_diff_out;
                        cap_value <= rsp.value;
                        cap_ovf   <= rsp.overflow;
                    end
                end
                S_UPDATE: begin
                    iter_count <= iter_inc;
                    if (cap_ovf) begin
                        err_ovf   <= 1'b1;
                        x_opt     <= x_cur;
                        value_opt <= cap_value;
                    end else if (hit_tol) begin
                        converged <= 1'b1;
                        x_opt     <= x_next;
                        value_opt <= cap_value;
                    end else if (hit_limit) begin
                        converged <= 1'b0;
                        x_opt     <= x_next;
                        value_opt <= cap_value;
                    end else begin
                        x_cur <= x_next;
                    end
                end
                default: ;
            endcase

            // Watchdog expiry reports the point that was being evaluated.
            if (timeout_hit)
                x_opt <= x_cur;
        end
    end

endmodule

// File: tb/tb_gd_iter_ctrl.sv
// Self-checking bench for gd_iter_ctrl: a 5-cycle responder model, directed
// runs with hand-computed results queued per run, and a monitor that pops and
// compares on every done pulse.
`timescale 1ns/1ps
module tb_gd_iter_ctrl;

    localparam int unsigned MAX_ITER    = 12;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int          LAT         = 5;

    typedef enum {M_CONST, M_HALF, M_HANG} mode_e;

    typedef struct {
        string       name;
        logic [31:0] x_opt;
        logic [63:0] vopt;
        logic [15:0] iter;
        logic        conv;
        logic        ovf;
        logic        tmo;
        int          pulses;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] x_init;
    logic        busy, done, converged, err_ovf, err_timeout;
    logic [31:0] x_opt;
    logic [63:0] value_opt;
    logic [15:0] iter_count;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    mode_e       mode       = M_CONST;
    logic [31:0] const_diff = '0;
    int          ovf_at     = 0;
    logic        hold_done  = 1'b0;

    gd_iter_ctrl_if rsp_if ();

    gd_iter_ctrl #(
        .MAX_ITER   (MAX_ITER),
        .TOL        (32'h0000_0001),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x_init     (x_init),
        .rsp        (rsp_if),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .err_ovf    (err_ovf),
        .err_timeout(err_timeout),
        .x_opt      (x_opt),
        .value_opt  (value_opt),
        .iter_count (iter_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [31:0] x, input logic [63:0] v,
                                input logic [15:0] it, input logic c, input logic o,
                                input logic t, input int p);
        exp_t e;
        e.name = n; e.x_opt = x; e.vopt = v; e.iter = it;
        e.conv = c; e.ovf = o; e.tmo = t; e.pulses = p;
        return e;
    endfunction

    // Responder model: samples x_in on start_func, drops a stale done two cycles
    // later, answers after LAT cycles; value = {C0DE, eval index in run, x_in}.
    initial begin : responder
        logic [31:0] xs;
        int          ev;
        ev = 0;
        rsp_if.func_done  = 1'b0;
        rsp_if.x_diff_out = '0;
        rsp_if.value      = '0;
        rsp_if.overflow   = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                ev = 0;
            end else if (rsp_if.start_func && mode != M_HANG) begin
                xs = rsp_if.x_in;
                ev++;
                for (int k = 1; k <= LAT; k++) begin
                    @(negedge clk);
                    if (k == 2) rsp_if.func_done = 1'b0;
                end
                rsp_if.x_diff_out = (mode == M_HALF) ? 32'($signed(xs) >>> 1) : const_diff;
                rsp_if.overflow   = (ovf_at != 0) && (ev == ovf_at);
                rsp_if.value      = {16'hC0DE, 16'(ev), xs};
                rsp_if.func_done  = 1'b1;
                if (!hold_done) begin
                    @(negedge clk);
                    rsp_if.func_done = 1'b0;
                end
            end
        end
    end

    // Monitor: counts launches per run and scores each done pulse
    initial begin : monitor
        int   pulses;
        exp_t e;
        pulses = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pulses = 0;
            end else begin
                if (rsp_if.start_func) pulses++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, ".x_opt"},       64'(x_opt),       64'(e.x_opt));
                        check({e.name, ".value_opt"},   value_opt,        e.vopt);
                        check({e.name, ".iter_count"},  64'(iter_count),  64'(e.iter));
                        check({e.name, ".converged"},   64'(converged),   64'(e.conv));
                        check({e.name, ".err_ovf"},     64'(err_ovf),     64'(e.ovf));
                        check({e.name, ".err_timeout"}, 64'(err_timeout), 64'(e.tmo));
                        check({e.name, ".launches"},    64'(pulses),      64'(e.pulses));
                    end
                    pulses = 0;
                end
            end
        end
    end

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".completed"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run(input exp_t e, input logic [31:0] xi, input mode_e m,
                       input logic [31:0] cd, input int oa, input logic hold);
        mode = m; const_diff = cd; ovf_at = oa; hold_done = hold;
        x_init = xi;
        exp_q.push_back(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_empty(e.name);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"},        64'(busy),              64'd0);
        check({tag, ".done"},        64'(done),              64'd0);
        check({tag, ".start_func"},  64'(rsp_if.start_func), 64'd0);
        check({tag, ".x_in"},        64'(rsp_if.x_in),       64'd0);
        check({tag, ".x_opt"},       64'(x_opt),             64'd0);
        check({tag, ".value_opt"},   value_opt,              64'd0);
        check({tag, ".iter_count"},  64'(iter_count),        64'd0);
        check({tag, ".converged"},   64'(converged),         64'd0);
        check({tag, ".err_ovf"},     64'(err_ovf),           64'd0);
        check({tag, ".err_timeout"}, 64'(err_timeout),       64'd0);
    endtask

    initial begin : stim
        int gap;
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        x_init = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Constant step 0x100 from 0xA00 runs into the 12-evaluation limit:
        // last x_in = 0xA00 - 11*0x100 = -0x100, x_opt = -0x200.
        run(mk("limit", 32'hFFFF_FE00, 64'hC0DE_000C_FFFF_FF00, 16'd12, 1'b0, 1'b0, 1'b0, 12),
            32'h0000_0A00, M_CONST, 32'h0000_0100, 0, 1'b0);

        // Halving step from 0x400: steps 0x200..0x1 over 10 evaluations;
        // at x=0x2 the step 0x1 meets TOL, x_opt = 0x2 - 0x1 = 0x1.
        run(mk("halve", 32'h0000_0001, 64'hC0DE_000A_0000_0002, 16'd10, 1'b1, 1'b0, 1'b0, 10),
            32'h0000_0400, M_HALF, 32'h0, 0, 1'b0);

        // Overflow on the 2nd evaluation keeps the point that was evaluated.
        run(mk("ovf2", 32'h0000_00F0, 64'hC0DE_0002_0000_00F0, 16'd2, 1'b0, 1'b1, 1'b0, 2),
            32'h0000_0100, M_CONST, 32'h0000_0010, 2, 1'b0);

        // Most negative step: |step| clamps above TOL, x saturates high.
        run(mk("sat_pos", 32'h7FFF_FFFF, 64'hC0DE_0002_7FFF_FFFF, 16'd2, 1'b0, 1'b1, 1'b0, 2),
            32'h7FFF_FF00, M_CONST, 32'h8000_0000, 2, 1'b0);

        // Large positive step from near the bottom saturates low.
        run(mk("sat_neg", 32'h8000_0000, 64'hC0DE_0002_8000_0000, 16'd2, 1'b0, 1'b1, 1'b0, 2),
            32'h8000_0100, M_CONST, 32'h7FFF_FFFF, 2, 1'b0);

        // Step of -1 has magnitude exactly TOL: converges on the first evaluation.
        run(mk("tol_neg", 32'h0000_0001, 64'hC0DE_0001_0000_0000, 16'd1, 1'b1, 1'b0, 1'b0, 1),
            32'h0000_0000, M_CONST, 32'hFFFF_FFFF, 0, 1'b0);

        // Responder holds done high into the next launch: one update per evaluation.
        run(mk("hold", 32'h0000_0001, 64'hC0DE_0003_0000_0002, 16'd3, 1'b1, 1'b0, 1'b0, 3),
            32'h0000_0008, M_HALF, 32'h0, 0, 1'b1);

        // Reset during WAIT_HIGH: launch seen at n0, response due at n5.
        mode = M_CONST; const_diff = 32'h0000_0100; ovf_at = 0; hold_done = 1'b0;
        x_init = 32'h0000_1234;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!rsp_if.start_func && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("midrun.launch_seen", 64'(rsp_if.start_func), 64'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrun");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // start held high: two runs with one IDLE cycle between them.
        mode = M_CONST; const_diff = 32'h0000_0010; ovf_at = 1; hold_done = 1'b0;
        x_init = 32'h0000_0500;
        exp_q.push_back(mk("b2b_1", 32'h0000_0500, 64'hC0DE_0001_0000_0500, 16'd1, 1'b0, 1'b1, 1'b0, 1));
        exp_q.push_back(mk("b2b_2", 32'h0000_0500, 64'hC0DE_0001_0000_0500, 16'd1, 1'b0, 1'b1, 1'b0, 1));
        @(negedge clk) start = 1'b1;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        gap = 0;
        while (gap < 10) begin
            @(negedge clk);
            gap++;
            if (rsp_if.start_func) break;
        end
        check("b2b.done_to_launch", 64'(gap), 64'd2);
        start = 1'b0;
        wait_empty("b2b");

`ifdef GD_TIMEOUT_EN
        // Silent responder: watchdog ends the run, value_opt keeps the prior run's.
        run(mk("timeout", 32'h0000_0300, 64'hC0DE_0001_0000_0500, 16'd0, 1'b0, 1'b0, 1'b1, 1),
            32'h0000_0300, M_HANG, 32'h0, 0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
